eth_udp_rcv: RTL and testbench
==============================

Name: eth_udp_rcv

Overview:
- GMII-side receiver for UDP/IPv4 over Ethernet; the receive counterpart of the design's UDP transmit path.
- Sits after an RGMII-to-GMII converter in the RX clock domain.
- Strips preamble and Ethernet/IP/UDP headers, filters on local MAC/IP/port, and streams the UDP payload bytewise.
- Checks the FCS (CRC-32) and reports frame pass/fail after the frame ends.

Parameters:
- CHECK_CRC, 1, 1: FCS verified and Rx_Err on mismatch; 0: FCS ignored.
- ACCEPT_BCAST, 1, 1: dest MAC FF_FF_FF_FF_FF_FF also accepted.

Ports:
- Clk  in  1  GMII receive clock, 125 MHz (the single clock).
- Rst  in  1  asynchronous active-high reset.
- GMII_RXDV  in  1  receive data valid.
- GMII_RXD  in  8  receive data byte.
- GMII_RXER  in  1  receive error.
- local_mac  in  48  station MAC address.
- local_ip  in  32  station IP address.
- local_port  in  16  accepted UDP destination port.
- data_valid  out  1  payload byte strobe.
- data_out  out  8  payload byte.
- data_sof  out  1  with first payload byte.
- data_eof  out  1  with last payload byte.
- data_length  out  16  UDP payload length (UDP length − 8), valid from first data_valid until next frame.
- src_ip  out  32  sender IP, latched per frame, valid with data_length.
- src_port  out  16  sender UDP source port, valid with data_length.
- Rx_Done  out  1  one-cycle pulse: accepted frame ended cleanly.
- Rx_Err  out  1  one-cycle pulse: accepted frame ended badly.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; CRC register set to FFFF_FFFF.
- FSM states and transitions:
  - IDLE: RXDV=1 and RXD=55 → PREAMBLE.
  - PREAMBLE: 55 stays; D5 → ETH_HDR; any other byte → DROP. Accept 1–7 bytes of 55 before D5.
  - ETH_HDR: 14 bytes. Dest MAC must equal local_mac (or broadcast when ACCEPT_BCAST=1). Type must be 0800. Else → DROP.
  - IP_HDR: 20 bytes. Byte0 must be 45 (IHL≠5 → DROP). Protocol must be 11. Dest IP must equal local_ip. Src IP latched. IP checksum not checked.
  - UDP_HDR: 8 bytes. Dest port must equal local_port. Src port and length latched. UDP length <8 → DROP.
  - PAYLOAD: emits UDP length − 8 bytes, then → TRAIL.
  - TRAIL: consumes pad and FCS until RXDV=0.
  - DROP: waits for RXDV=0, then → IDLE; never pulses Rx_Done or Rx_Err.
- Header comparisons are done on the fly. A mismatch is detected on the offending byte; transition to DROP occurs on the next edge.
- Payload output is registered: data_out/data_valid appear 1 Clk after the byte is on GMII_RXD.
- data_sof and data_eof coincide for a 1-byte payload.
- Zero-length payload (UDP length = 8): no data_valid; data_length=0; frame still completes with Rx_Done/Rx_Err.
- data_length, src_ip and src_port update on the cycle data_sof asserts; for zero-length payload they update when UDP_HDR completes.
- CRC-32 (reflected, poly 04C11DB7) runs over bytes from dest MAC through FCS. Good frame residue is C704DD7B.
- End of frame = first cycle RXDV=0 while in UDP_HDR/PAYLOAD/TRAIL. One cycle later exactly one of the following pulses, then FSM → IDLE:
  - Rx_Done: CRC good (or CHECK_CRC=0), no RXER seen since SFD, and all payload bytes emitted.
  - Rx_Err: any other case.
- RXDV falls inside ETH_HDR/IP_HDR: silent → IDLE.
- RXDV falls mid-PAYLOAD: data_eof never asserts; Rx_Err pulses.
- GMII_RXER with RXDV=1 sets a sticky per-frame error flag. Streaming continues; the frame ends with Rx_Err.
- Back-to-back frames: one idle cycle (RXDV=0) is sufficient. The Rx_Done/Rx_Err pulse may coincide with the next frame's first preamble byte, which IDLE must accept.
- Rst mid-frame: outputs clear immediately. After release, the remainder of the frame is ignored until RXDV=0 is observed (start in DROP if RXDV=1 at release).

Test Plan:
- Unicast frame, 7×55+D5, dest MAC=local_mac, IP 192.168.0.3, port 6102, 4-byte payload DE AD BE EF, valid FCS → 4 data_valid (sof on DE, eof on EF), data_length=4, src_ip=C0A80002, src_port=5000, Rx_Done one cycle after RXDV falls.
- Same frame with one FCS bit flipped → identical payload stream, Rx_Err pulse, no Rx_Done; with CHECK_CRC=0 → Rx_Done.
- Wrong dest port (6103), wrong IP, ethertype 0806, and IP byte0=46, each with valid FCS → no data_valid, no Rx_Done/Rx_Err.
- Payload of 2562 bytes, then a second frame after a 1-cycle gap with a 1-byte payload → 2562 bytes then 1 byte with sof=eof=1; two Rx_Done pulses.
- RXDV dropped after 100 of 200 payload bytes → 100 data_valid, no data_eof, Rx_Err. GMII_RXER pulsed during payload → full stream, Rx_Err.
- Rst asserted mid-payload then released with RXDV=1 → outputs 0, remaining bytes ignored; the next clean frame is received with Rx_Done.

Source files
------------

// File: rtl/eth_udp_rcv.sv
// ---------------------------------------------------------------------------
// eth_udp_rcv
//   GMII-side UDP/IPv4 receiver. Locks onto preamble/SFD, checks the Ethernet,
//   IPv4 and UDP headers on the fly against the station address/port, streams
//   the UDP payload one byte per cycle, and reports the frame outcome with a
//   single Rx_Done / Rx_Err pulse one cycle after GMII_RXDV falls.
//
// Ports
//   Clk, Rst          : GMII RX clock (125 MHz), async active-high reset
//   GMII_RXDV/RXD/RXER: GMII receive interface
//   local_mac/ip/port : station MAC, IP and accepted UDP destination port
//   data_valid/out    : registered payload byte strobe and byte
//   data_sof/eof      : first / last payload byte markers
//   data_length       : UDP payload length (UDP length - 8)
//   src_ip/src_port   : sender IP and UDP source port of the current frame
//   Rx_Done/Rx_Err    : one-cycle frame outcome pulses for accepted frames
// ---------------------------------------------------------------------------
module eth_udp_rcv #(
  parameter bit CHECK_CRC    = 1'b1,
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        GMII_RXDV,
  input  logic [7:0]  GMII_RXD,
  input  logic        GMII_RXER,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  output logic        data_valid,
  output logic [7:0]  data_out,
  output logic        data_sof,
  output logic        data_eof,
  output logic [15:0] data_length,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic        Rx_Done,
  output logic        Rx_Err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR,
    S_UDP_HDR, S_PAYLOAD, S_TRAIL, S_DROP
  } state_t;

  state_t      state, next_state;
  logic [4:0]  byte_cnt;
  logic [2:0]  pre_cnt;
  logic [15:0] udp_len;
  logic [15:0] pay_len;
  logic [15:0] pay_cnt;
  logic [31:0] crc;
  logic [31:0] ip_src_tmp;
  logic [15:0] port_src_tmp;
  logic        uni_ok, bc_ok;
  logic        need_idle;
  logic        err_flag;
  logic        pay_done;

  logic        hdr_ok;
  logic        mac_uni_hit, mac_bc_hit;
  logic        crc_ok, frame_end, frame_good, pay_last;

  // One byte of the reflected CRC-32 (poly 04C11DB7, LSB first).
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // The residue constant is quoted MSB-first, the register is LSB-first.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
    case (i)
      3'd0:    return m[47:40];
      3'd1:    return m[39:32];
      3'd2:    return m[31:24];
      3'd3:    return m[23:16];
      3'd4:    return m[15:8];
      default: return m[7:0];
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] i);
    case (i)
      2'd0:    return a[31:24];
      2'd1:    return a[23:16];
      2'd2:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

  // Per-byte header check for the byte currently on GMII_RXD. The MAC match
  // is tracked separately for unicast and broadcast so that a mix of the two
  // across bytes is rejected.
  always_comb begin
    mac_uni_hit = (GMII_RXD == mac_byte(local_mac, byte_cnt[2:0]));
    mac_bc_hit  = ACCEPT_BCAST && (GMII_RXD == 8'hFF);
    hdr_ok      = 1'b1;
    case (state)
      S_ETH_HDR: begin
        if (byte_cnt < 5'd6)       hdr_ok = (uni_ok && mac_uni_hit) || (bc_ok && mac_bc_hit);
        else if (byte_cnt == 5'd12) hdr_ok = (GMII_RXD == 8'h08);
        else if (byte_cnt == 5'd13) hdr_ok = (GMII_RXD == 8'h00);
      end
      S_IP_HDR: begin
        if (byte_cnt == 5'd0)       hdr_ok = (GMII_RXD == 8'h45);
        else if (byte_cnt == 5'd9)  hdr_ok = (GMII_RXD == 8'h11);
        else if (byte_cnt >= 5'd16) hdr_ok = (GMII_RXD == ip_byte(local_ip, byte_cnt[1:0]));
      end
      S_UDP_HDR: begin
        if (byte_cnt == 5'd2)      hdr_ok = (GMII_RXD == local_port[15:8]);
        else if (byte_cnt == 5'd3) hdr_ok = (GMII_RXD == local_port[7:0]);
        else if (byte_cnt == 5'd5) hdr_ok = ({udp_len[15:8], GMII_RXD} >= 16'd8);
      end
      default: hdr_ok = 1'b1;
    endcase
  end

  // Frame outcome: evaluated on the first RXDV-low cycle after the UDP header
  // has started, when the CRC register already holds every received byte.
  always_comb begin
    crc_ok     = (bit_rev32(crc) == 32'hC704DD7B);
    frame_end  = !GMII_RXDV && (state inside {S_UDP_HDR, S_PAYLOAD, S_TRAIL});
    frame_good = (crc_ok || (CHECK_CRC == 1'b0)) && !err_flag && pay_done;
    pay_last   = (pay_cnt == (pay_len - 16'd1));
  end

  // Next-state logic. After a reset that lands mid-frame, need_idle keeps
  // the receiver in DROP until the line has been seen idle once.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:
        if (GMII_RXDV) begin
          if (!need_idle && GMII_RXD == 8'h55) next_state = S_PREAMBLE;
          else                                 next_state = S_DROP;
        end
      S_PREAMBLE:
        if (!GMII_RXDV)                             next_state = S_IDLE;
        else if (GMII_RXD == 8'hD5)                 next_state = S_ETH_HDR;
        else if (GMII_RXD != 8'h55 || pre_cnt == 3'd7) next_state = S_DROP;
      S_ETH_HDR:
        if (!GMII_RXDV)             next_state = S_IDLE;
        else if (!hdr_ok)           next_state = S_DROP;
        else if (byte_cnt == 5'd13) next_state = S_IP_HDR;
      S_IP_HDR:
        if (!GMII_RXDV)             next_state = S_IDLE;
        else if (!hdr_ok)           next_state = S_DROP;
        else if (byte_cnt == 5'd19) next_state = S_UDP_HDR;
      S_UDP_HDR:
        if (!GMII_RXDV)             next_state = S_IDLE;
        else if (!hdr_ok)           next_state = S_DROP;
        else if (byte_cnt == 5'd7)  next_state = (udp_len == 16'd8) ? S_TRAIL : S_PAYLOAD;
      S_PAYLOAD:
        if (!GMII_RXDV)             next_state = S_IDLE;
        else if (pay_last)          next_state = S_TRAIL;
      S_TRAIL:
        if (!GMII_RXDV)             next_state = S_IDLE;
      S_DROP:
        if (!GMII_RXDV)             next_state = S_IDLE;
      default:                      next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Datapath: header capture, CRC, payload output and outcome pulses.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      byte_cnt     <= '0;
      pre_cnt      <= '0;
      udp_len      <= '0;
      pay_len      <= '0;
      pay_cnt      <= '0;
      crc          <= 32'hFFFF_FFFF;
      ip_src_tmp   <= '0;
      port_src_tmp <= '0;
      uni_ok       <= 1'b0;
      bc_ok        <= 1'b0;
      need_idle    <= 1'b1;
      err_flag     <= 1'b0;
      pay_done     <= 1'b0;
      data_valid   <= 1'b0;
      data_out     <= '0;
      data_sof     <= 1'b0;
      data_eof     <= 1'b0;
      data_length  <= '0;
      src_ip       <= '0;
      src_port     <= '0;
      Rx_Done      <= 1'b0;
      Rx_Err       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      data_sof   <= 1'b0;
      data_eof   <= 1'b0;
      Rx_Done    <= 1'b0;
      Rx_Err     <= 1'b0;
      byte_cnt   <= (next_state != state) ? 5'd0 : byte_cnt + 5'd1;

      if (!GMII_RXDV) need_idle <= 1'b0;

      if (frame_end) begin
        Rx_Done <= frame_good;
        Rx_Err  <= !frame_good;
      end

      case (state)
        S_IDLE: begin
          crc     <= 32'hFFFF_FFFF;
          pre_cnt <= 3'd1;
        end
        S_PREAMBLE: begin
          crc      <= 32'hFFFF_FFFF;
          pre_cnt  <= pre_cnt + 3'd1;
          uni_ok   <= 1'b1;
          bc_ok    <= 1'b1;
          err_flag <= 1'b0;
          pay_done <= 1'b0;
        end
        S_DROP: crc <= 32'hFFFF_FFFF;
        default: ;
      endcase

      if ((state inside {S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_TRAIL}) && GMII_RXDV) begin
        crc <= crc32_byte(crc, GMII_RXD);
        if (GMII_RXER) err_flag <= 1'b1;
      end

      if (state == S_ETH_HDR && byte_cnt < 5'd6) begin
        uni_ok <= uni_ok && mac_uni_hit;
        bc_ok  <= bc_ok && mac_bc_hit;
      end

      if (state == S_IP_HDR && GMII_RXDV) begin
        case (byte_cnt)
          5'd12:   ip_src_tmp[31:24] <= GMII_RXD;
          5'd13:   ip_src_tmp[23:16] <= GMII_RXD;
          5'd14:   ip_src_tmp[15:8]  <= GMII_RXD;
          5'd15:   ip_src_tmp[7:0]   <= GMII_RXD;
          default: ;
        endcase
      end

      // Zero-length payload publishes its frame info at the end of the
      // UDP header since there is no first payload byte to carry it.
      if (state == S_UDP_HDR && GMII_RXDV) begin
        case (byte_cnt)
          5'd0: port_src_tmp[15:8] <= GMII_RXD;
          5'd1: port_src_tmp[7:0]  <= GMII_RXD;
          5'd4: udp_len[15:8]      <= GMII_RXD;
          5'd5: udp_len[7:0]       <= GMII_RXD;
          5'd7: begin
            pay_len <= udp_len - 16'd8;
            pay_cnt <= '0;
            if (udp_len == 16'd8) begin
              pay_done    <= 1'b1;
              data_length <= '0;
              src_ip      <= ip_src_tmp;
              src_port    <= port_src_tmp;
            end
          end
          default: ;
        endcase
      end

      if (state == S_PAYLOAD && GMII_RXDV) begin
        data_valid <= 1'b1;
        data_out   <= GMII_RXD;
        data_sof   <= (pay_cnt == 16'd0);
        data_eof   <= pay_last;
        pay_cnt    <= pay_cnt + 16'd1;
        if (pay_cnt == 16'd0) begin
          data_length <= pay_len;
          src_ip      <= ip_src_tmp;
          src_port    <= port_src_tmp;
        end
        if (pay_last) pay_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_udp_rcv.sv
// ---------------------------------------------------------------------------
// tb_eth_udp_rcv
//   Directed bench for eth_udp_rcv. Frames are assembled byte by byte with a
//   locally computed FCS, driven onto GMII, and the payload stream and outcome
//   pulses are compared with hand-derived expectations. A second instance with
//   CHECK_CRC=0 shares the same inputs.
// ---------------------------------------------------------------------------
module tb_eth_udp_rcv;

  localparam logic [47:0] LMAC  = 48'h02_12_34_56_78_9A;
  localparam logic [31:0] LIP   = 32'hC0A8_0003;
  localparam logic [15:0] LPORT = 16'd6102;

  localparam int C_VALID = 0, C_SOF = 1, C_EOF = 2, C_ONE = 3;
  localparam int C_DONE = 4, C_ERR = 5, C_DONE_NC = 6, C_ERR_NC = 7;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        rxdv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rxer = 1'b0;

  logic        data_valid, data_sof, data_eof, Rx_Done, Rx_Err;
  logic [7:0]  data_out;
  logic [15:0] data_length, src_port;
  logic [31:0] src_ip;

  logic        nc_valid, nc_sof, nc_eof, nc_done, nc_err;
  logic [7:0]  nc_out;
  logic [15:0] nc_length, nc_port;
  logic [31:0] nc_ip;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          done_cyc = 0;
  int          cnt [8] = '{default: 0};
  int          snap [8] = '{default: 0};
  int          rx_base = 0;
  logic [7:0]  sof_byte = 8'h00;
  logic [7:0]  eof_byte = 8'h00;
  logic [15:0] cap_len = 16'h0;
  logic [31:0] cap_ip = 32'h0;
  logic [15:0] cap_port = 16'h0;

  logic [7:0]  frame [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];

  eth_udp_rcv #(.CHECK_CRC(1'b1), .ACCEPT_BCAST(1'b1)) dut (
    .Clk(Clk), .Rst(Rst),
    .GMII_RXDV(rxdv), .GMII_RXD(rxd), .GMII_RXER(rxer),
    .local_mac(LMAC), .local_ip(LIP), .local_port(LPORT),
    .data_valid(data_valid), .data_out(data_out),
    .data_sof(data_sof), .data_eof(data_eof),
    .data_length(data_length), .src_ip(src_ip), .src_port(src_port),
    .Rx_Done(Rx_Done), .Rx_Err(Rx_Err)
  );

  eth_udp_rcv #(.CHECK_CRC(1'b0), .ACCEPT_BCAST(1'b1)) dut_nc (
    .Clk(Clk), .Rst(Rst),
    .GMII_RXDV(rxdv), .GMII_RXD(rxd), .GMII_RXER(rxer),
    .local_mac(LMAC), .local_ip(LIP), .local_port(LPORT),
    .data_valid(nc_valid), .data_out(nc_out),
    .data_sof(nc_sof), .data_eof(nc_eof),
    .data_length(nc_length), .src_ip(nc_ip), .src_port(nc_port),
    .Rx_Done(nc_done), .Rx_Err(nc_err)
  );

  always #4 Clk = ~Clk;

  always @(posedge Clk) cyc = cyc + 1;

  // Monitor: outputs are sampled on the falling edge, away from the
  // active edge, and accumulated into running counters.
  always @(negedge Clk) begin
    if (data_valid) begin
      rx_q.push_back(data_out);
      cnt[C_VALID] = cnt[C_VALID] + 1;
      if (data_sof) begin
        cnt[C_SOF] = cnt[C_SOF] + 1;
        sof_byte = data_out;
        cap_len  = data_length;
        cap_ip   = src_ip;
        cap_port = src_port;
      end
      if (data_eof) begin
        cnt[C_EOF] = cnt[C_EOF] + 1;
        eof_byte = data_out;
      end
      if (data_sof && data_eof) cnt[C_ONE] = cnt[C_ONE] + 1;
    end
    if (Rx_Done) begin
      cnt[C_DONE] = cnt[C_DONE] + 1;
      done_cyc = cyc;
    end
    if (Rx_Err)  cnt[C_ERR] = cnt[C_ERR] + 1;
    if (nc_done) cnt[C_DONE_NC] = cnt[C_DONE_NC] + 1;
    if (nc_err)  cnt[C_ERR_NC] = cnt[C_ERR_NC] + 1;
  end

  // Compare one observed value with its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Start a new test: remember counter positions and clear the expected stream.
  task automatic take_snap();
    for (int i = 0; i < 8; i++) snap[i] = cnt[i];
    rx_base = rx_q.size();
    exp_q.delete();
  endtask

  function automatic int delta(input int idx);
    return cnt[idx] - snap[idx];
  endfunction

  function automatic int count_bad(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (rx_base + i >= rx_q.size() || i >= exp_q.size()) bad++;
      else if (rx_q[rx_base + i] !== exp_q[i]) bad++;
    end
    return bad;
  endfunction

  // Assemble Ethernet + IPv4 + UDP + payload + FCS into 'frame'. The payload
  // is either DE AD BE EF or seed^index; it is also appended to exp_q.
  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                             input logic [7:0] ipb0, input logic [31:0] dip,
                             input logic [15:0] dport, input int plen,
                             input logic [7:0] seed, input bit use_dead);
    logic [31:0] c;
    logic [31:0] dead;
    logic [15:0] ulen;
    logic [15:0] tot;
    logic [7:0]  b;
    dead = 32'hDEADBEEF;
    ulen = 16'(plen + 8);
    tot  = 16'(plen + 28);
    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(8'(dmac >> (40 - 8*i)));
    frame.push_back(8'h02); frame.push_back(8'h00); frame.push_back(8'h00);
    frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h01);
    frame.push_back(etype[15:8]); frame.push_back(etype[7:0]);
    frame.push_back(ipb0); frame.push_back(8'h00);
    frame.push_back(tot[15:8]); frame.push_back(tot[7:0]);
    frame.push_back(8'h00); frame.push_back(8'h01);
    frame.push_back(8'h40); frame.push_back(8'h00);
    frame.push_back(8'h40); frame.push_back(8'h11);
    frame.push_back(8'h00); frame.push_back(8'h00);
    frame.push_back(8'hC0); frame.push_back(8'hA8);
    frame.push_back(8'h00); frame.push_back(8'h02);
    for (int i = 0; i < 4; i++) frame.push_back(8'(dip >> (24 - 8*i)));
    frame.push_back(8'h13); frame.push_back(8'h88);
    frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
    frame.push_back(ulen[15:8]); frame.push_back(ulen[7:0]);
    frame.push_back(8'h00); frame.push_back(8'h00);
    for (int i = 0; i < plen; i++) begin
      if (use_dead) b = 8'(dead >> (24 - 8*i));
      else          b = seed ^ 8'(i);
      frame.push_back(b);
      exp_q.push_back(b);
    end
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < frame.size(); i++) c = crc_step(c, frame[i]);
    c = ~c;
    frame.push_back(c[7:0]);   frame.push_back(c[15:8]);
    frame.push_back(c[23:16]); frame.push_back(c[31:24]);
  endtask

  // Drive 7x55 + D5 and the first nsend bytes of 'frame'. Optional RXER on
  // one byte, optional reset pulse starting at one byte, then RXDV low for
  // 'gap' cycles (gap=1 gives a single idle cycle before the next call).
  task automatic applyStimulus(input int nsend, input int rxer_at, input int rst_at, input int gap);
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      rxdv = 1'b1; rxer = 1'b0;
      rxd  = (k == 7) ? 8'hD5 : 8'h55;
    end
    for (int k = 0; k < nsend; k++) begin
      @(posedge Clk); #1;
      rxdv = 1'b1;
      rxd  = frame[k];
      rxer = (k == rxer_at);
      if (k == rst_at) begin
        Rst = 1'b1;
        #1;
        checkOutput("rst_clear",
                    32'(|{data_valid, data_sof, data_eof, Rx_Done, Rx_Err,
                          data_out, data_length, src_ip, src_port}), 32'd0);
      end
      if (rst_at >= 0 && k == rst_at + 2) Rst = 1'b0;
    end
    @(posedge Clk); #1;
    rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
    fall_cyc = cyc;
    for (int g = 1; g < gap; g++) @(posedge Clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rst_valid", 32'(data_valid), 32'd0);
    checkOutput("rst_done",  32'(Rx_Done), 32'd0);
    checkOutput("rst_err",   32'(Rx_Err), 32'd0);
    checkOutput("rst_len",   32'(data_length), 32'd0);
    checkOutput("rst_srcip", src_ip, 32'd0);
    Rst = 1'b0;
    repeat (3) @(posedge Clk);

    // Unicast 4-byte payload, good FCS
    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 4, 8'h00, 1'b1);
    applyStimulus(frame.size(), -1, -1, 10);
    checkOutput("t1_valid",  32'(delta(C_VALID)), 32'd4);
    checkOutput("t1_sof",    32'(delta(C_SOF)), 32'd1);
    checkOutput("t1_eof",    32'(delta(C_EOF)), 32'd1);
    checkOutput("t1_bytes",  32'(count_bad(4)), 32'd0);
    checkOutput("t1_sofb",   32'(sof_byte), 32'hDE);
    checkOutput("t1_eofb",   32'(eof_byte), 32'hEF);
    checkOutput("t1_len",    32'(cap_len), 32'd4);
    checkOutput("t1_srcip",  cap_ip, 32'hC0A8_0002);
    checkOutput("t1_port",   32'(cap_port), 32'd5000);
    checkOutput("t1_done",   32'(delta(C_DONE)), 32'd1);
    checkOutput("t1_err",    32'(delta(C_ERR)), 32'd0);
    checkOutput("t1_latency", 32'(done_cyc - fall_cyc), 32'd1);

    // Same frame with one FCS bit flipped
    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 4, 8'h00, 1'b1);
    frame[frame.size()-1] = frame[frame.size()-1] ^ 8'h01;
    applyStimulus(frame.size(), -1, -1, 10);
    checkOutput("fcs_valid",   32'(delta(C_VALID)), 32'd4);
    checkOutput("fcs_bytes",   32'(count_bad(4)), 32'd0);
    checkOutput("fcs_err",     32'(delta(C_ERR)), 32'd1);
    checkOutput("fcs_done",    32'(delta(C_DONE)), 32'd0);
    checkOutput("fcs_nc_done", 32'(delta(C_DONE_NC)), 32'd1);
    checkOutput("fcs_nc_err",  32'(delta(C_ERR_NC)), 32'd0);

    // Filtered frames: wrong port, wrong IP, ARP ethertype, IHL 6
    for (int v = 0; v < 4; v++) begin
      take_snap();
      case (v)
        0:       build_frame(LMAC, 16'h0800, 8'h45, LIP, 16'd6103, 4, 8'h00, 1'b1);
        1:       build_frame(LMAC, 16'h0800, 8'h45, 32'hC0A8_0004, LPORT, 4, 8'h00, 1'b1);
        2:       build_frame(LMAC, 16'h0806, 8'h45, LIP, LPORT, 4, 8'h00, 1'b1);
        default: build_frame(LMAC, 16'h0800, 8'h46, LIP, LPORT, 4, 8'h00, 1'b1);
      endcase
      applyStimulus(frame.size(), -1, -1, 10);
      checkOutput($sformatf("drop%0d_valid", v), 32'(delta(C_VALID)), 32'd0);
      checkOutput($sformatf("drop%0d_pulse", v), 32'(delta(C_DONE) + delta(C_ERR)), 32'd0);
    end

    // Long payload, one idle cycle, then a 1-byte payload
    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 2562, 8'h3C, 1'b0);
    applyStimulus(frame.size(), -1, -1, 1);
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 1, 8'hA5, 1'b0);
    applyStimulus(frame.size(), -1, -1, 10);
    checkOutput("b2b_valid", 32'(delta(C_VALID)), 32'd2563);
    checkOutput("b2b_sof",   32'(delta(C_SOF)), 32'd2);
    checkOutput("b2b_eof",   32'(delta(C_EOF)), 32'd2);
    checkOutput("b2b_one",   32'(delta(C_ONE)), 32'd1);
    checkOutput("b2b_done",  32'(delta(C_DONE)), 32'd2);
    checkOutput("b2b_err",   32'(delta(C_ERR)), 32'd0);
    checkOutput("b2b_bytes", 32'(count_bad(2563)), 32'd0);
    checkOutput("b2b_len",   32'(cap_len), 32'd1);

    // RXDV drops after 100 of 200 payload bytes
    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 200, 8'h11, 1'b0);
    applyStimulus(42 + 100, -1, -1, 10);
    checkOutput("trunc_valid", 32'(delta(C_VALID)), 32'd100);
    checkOutput("trunc_eof",   32'(delta(C_EOF)), 32'd0);
    checkOutput("trunc_err",   32'(delta(C_ERR)), 32'd1);
    checkOutput("trunc_done",  32'(delta(C_DONE)), 32'd0);
    checkOutput("trunc_bytes", 32'(count_bad(100)), 32'd0);

    // RXER on one payload byte
    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 20, 8'h77, 1'b0);
    applyStimulus(frame.size(), 42 + 10, -1, 10);
    checkOutput("rxer_valid", 32'(delta(C_VALID)), 32'd20);
    checkOutput("rxer_eof",   32'(delta(C_EOF)), 32'd1);
    checkOutput("rxer_err",   32'(delta(C_ERR)), 32'd1);
    checkOutput("rxer_done",  32'(delta(C_DONE)), 32'd0);

    // Zero-length payload
    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 0, 8'h00, 1'b0);
    applyStimulus(frame.size(), -1, -1, 10);
    checkOutput("zero_valid", 32'(delta(C_VALID)), 32'd0);
    checkOutput("zero_done",  32'(delta(C_DONE)), 32'd1);
    checkOutput("zero_err",   32'(delta(C_ERR)), 32'd0);
    checkOutput("zero_len",   32'(data_length), 32'd0);
    checkOutput("zero_port",  32'(src_port), 32'd5000);

    // Reset mid-payload, released while RXDV is still high
    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 200, 8'h22, 1'b0);
    applyStimulus(frame.size(), -1, 42 + 50, 10);
    checkOutput("rstmid_valid", 32'(delta(C_VALID)), 32'd49);
    checkOutput("rstmid_done",  32'(delta(C_DONE)), 32'd0);
    checkOutput("rstmid_err",   32'(delta(C_ERR)), 32'd0);

    take_snap();
    build_frame(LMAC, 16'h0800, 8'h45, LIP, LPORT, 4, 8'h00, 1'b1);
    applyStimulus(frame.size(), -1, -1, 10);
    checkOutput("after_valid", 32'(delta(C_VALID)), 32'd4);
    checkOutput("after_done",  32'(delta(C_DONE)), 32'd1);
    checkOutput("after_err",   32'(delta(C_ERR)), 32'd0);
    checkOutput("after_bytes", 32'(count_bad(4)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
